// File: rtl/mmio_router.sv
// Routes host memory requests either to a small register window (IO slots)
// or through to the SDRAM driver, with a completion timeout on DRAM accesses.
module mmio_router #(
    parameter int                      ADDR_WIDTH  = 16,
    parameter int                      DATA_WIDTH  = 16,
    parameter int                      IO_AW       = 3,
    parameter logic [ADDR_WIDTH-1:0]   IO_BASE     = 16'h0100,
    parameter int                      IO_COUNT    = 4,
    parameter logic [IO_COUNT-1:0]     RO_MASK     = 4'b0000,
    parameter logic [DATA_WIDTH-1:0]   SLOT0_RESET = 16'hBEEF,
    parameter int                      TIMEOUT     = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_data_in,
    input  logic                           mem_r_en,
    input  logic                           mem_w_en,
    output logic                           mem_rdy,
    output logic                           mem_cplt,
    output logic [DATA_WIDTH-1:0]          mem_data_out,
    output logic                           dram_r_en,
    output logic                           dram_w_en,
    input  logic                           dram_rdy,
    input  logic                           dram_cplt,
    input  logic [DATA_WIDTH-1:0]          dram_data_out,
    input  logic [IO_COUNT*DATA_WIDTH-1:0] io_in,
    output logic [IO_COUNT*DATA_WIDTH-1:0] io_regs,
    output logic [IO_COUNT-1:0]            io_wr_strobe,
    output logic                           err_timeout,
    output logic                           err_decode
);

    typedef enum logic [1:0] {IDLE, IO_RESP, DRAM_WAIT, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [15:0]             cnt;
    logic                    rsp_vld_p1;
    logic [DATA_WIDTH-1:0]   rsp_data_p1;

    logic                    req, is_rd, is_wr, io_hit, io_acc, to_hit;
    logic [IO_AW-1:0]        slot;
    logic                    slot_impl, slot_ro, dec_err;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic [IO_COUNT-1:0]     wr_sel;

    assign mem_rdy   = (state == IDLE) & dram_rdy;
    assign req       = mem_rdy & (mem_r_en | mem_w_en);
    assign is_rd     = mem_r_en;
    assign is_wr     = mem_w_en & ~mem_r_en;
    assign io_hit    = mem_addr[ADDR_WIDTH-1:IO_AW] == IO_BASE[ADDR_WIDTH-1:IO_AW];
    assign slot      = mem_addr[IO_AW-1:0];
    assign io_acc    = req & io_hit;
    assign dram_r_en = req & is_rd & ~io_hit;
    assign dram_w_en = req & is_wr & ~io_hit;

    // cnt holds the number of wait cycles already elapsed before this one
    assign to_hit = (state == DRAM_WAIT) & ~dram_cplt & (cnt == 16'(TIMEOUT - 1));

    assign mem_cplt     = (state == DRAM_WAIT) ? dram_cplt     : rsp_vld_p1;
    assign mem_data_out = (state == DRAM_WAIT) ? dram_data_out : rsp_data_p1;

    always_comb begin
        rd_val    = '0;
        slot_impl = 1'b0;
        slot_ro   = 1'b0;
        wr_sel    = '0;
        for (int i = 0; i < IO_COUNT; i++) begin
            if (slot == IO_AW'(i)) begin
                slot_impl = 1'b1;
                slot_ro   = RO_MASK[i];
                rd_val    = RO_MASK[i] ? io_in[i*DATA_WIDTH +: DATA_WIDTH]
                                       : io_regs[i*DATA_WIDTH +: DATA_WIDTH];
                wr_sel[i] = io_acc & is_wr & ~RO_MASK[i];
            end
        end
        dec_err = io_acc & (~slot_impl | (is_wr & slot_ro));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (req) state_nxt = io_hit ? IO_RESP : DRAM_WAIT;
            IO_RESP:   state_nxt = IDLE;
            DRAM_WAIT: begin
                if (dram_cplt)   state_nxt = IDLE;
                else if (to_hit) state_nxt = DRAIN;
            end
            DRAIN:     if (dram_cplt) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // p1: registered IO / timeout response, slot writes and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            cnt                     <= '0;
            rsp_vld_p1              <= 1'b0;
            rsp_data_p1             <= '0;
            io_regs                 <= '0;
            io_regs[DATA_WIDTH-1:0] <= SLOT0_RESET;
            io_wr_strobe            <= '0;
            err_timeout             <= 1'b0;
            err_decode              <= 1'b0;
        end else begin
            state        <= state_nxt;
            rsp_vld_p1   <= 1'b0;
            rsp_data_p1  <= '0;
            io_wr_strobe <= wr_sel;
            for (int i = 0; i < IO_COUNT; i++) begin
                if (wr_sel[i]) io_regs[i*DATA_WIDTH +: DATA_WIDTH] <= mem_data_in;
            end
            if (dec_err) err_decode <= 1'b1;
            if (io_acc) begin
                rsp_vld_p1  <= 1'b1;
                rsp_data_p1 <= is_rd ? rd_val : '0;
            end
            if (req & ~io_hit) cnt <= '0;
            if (state == DRAM_WAIT) cnt <= cnt + 16'd1;
            if (to_hit) begin
                rsp_vld_p1  <= 1'b1;
                rsp_data_p1 <= '1;
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router: expected completions go into a scoreboard
// queue, a negedge monitor pops and compares each mem_cplt pulse.
module tb_mmio_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr, mem_data_in;
    logic        mem_r_en, mem_w_en;
    logic        mem_rdy, mem_cplt;
    logic [15:0] mem_data_out;
    logic        dram_r_en, dram_w_en, dram_rdy, dram_cplt;
    logic [15:0] dram_data_out;
    logic [63:0] io_in, io_regs;
    logic [3:0]  io_wr_strobe;
    logic        err_timeout, err_decode;

    mmio_router #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .IO_AW(3), .IO_BASE(16'h0100),
        .IO_COUNT(4), .RO_MASK(4'b1000), .SLOT0_RESET(16'hBEEF), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_rdy(mem_rdy), .mem_cplt(mem_cplt), .mem_data_out(mem_data_out),
        .dram_r_en(dram_r_en), .dram_w_en(dram_w_en), .dram_rdy(dram_rdy),
        .dram_cplt(dram_cplt), .dram_data_out(dram_data_out),
        .io_in(io_in), .io_regs(io_regs), .io_wr_strobe(io_wr_strobe),
        .err_timeout(err_timeout), .err_decode(err_decode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          dram_r_cnt = 0;
    int          dram_w_cnt = 0;
    int          drv_delay = 5;
    logic [15:0] drv_data = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion must match the oldest expectation
    always @(negedge clk) begin
        if (dram_r_en === 1'b1) dram_r_cnt++;
        if (dram_w_en === 1'b1) dram_w_cnt++;
        if (mem_cplt === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cplt: got data %h at cycle %0d expected no completion",
                         mem_data_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cplt_data", 64'(mem_data_out), 64'(e.data));
                check("cplt_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // DRAM driver model: completes drv_delay cycles after the accept cycle
    initial begin
        dram_cplt     = 1'b0;
        dram_data_out = 16'h0000;
        forever begin
            @(negedge clk);
            if (dram_r_en === 1'b1 || dram_w_en === 1'b1) begin
                @(posedge clk);
                repeat (drv_delay - 1) @(posedge clk);
                #1 dram_cplt = 1'b1;
                dram_data_out = drv_data;
                @(posedge clk);
                #1 dram_cplt = 1'b0;
                dram_data_out = 16'h0000;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one request; returns #1 into the cycle after the accept edge
    task automatic req(input logic [15:0] addr, input logic [15:0] wd, input logic r,
                       input logic w, input logic [15:0] exp, input int lat, input bit push);
        int n = 0;
        while (mem_rdy !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        check("rdy_before_req", 64'(mem_rdy), 64'd1);
        mem_addr    = addr;
        mem_data_in = wd;
        mem_r_en    = r;
        mem_w_en    = w;
        if (push) sb.push_back('{data: exp, due: cyc + lat});
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick(1);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL cplt_timeout: got %0d pending completions expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int c;
        rst         = 1'b1;
        mem_addr    = '0;
        mem_data_in = '0;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        dram_rdy    = 1'b1;
        io_in       = {16'hA5A5, 48'h0};
        tick(2);
        check("rst_rdy", 64'(mem_rdy), 64'd1);
        check("rst_cplt", 64'(mem_cplt), 64'd0);
        check("rst_data", 64'(mem_data_out), 64'd0);
        check("rst_regs", io_regs, 64'h0000_0000_0000_BEEF);
        check("rst_strobe", 64'(io_wr_strobe), 64'd0);
        check("rst_errs", 64'({err_timeout, err_decode}), 64'd0);
        rst = 1'b0;
        tick(1);

        // IO read of slot 0
        req(16'h0100, 16'h0, 1'b1, 1'b0, 16'hBEEF, 1, 1'b1);
        check("io_rdy_low", 64'(mem_rdy), 64'd0);
        wait_drain(10);
        check("io_rdy_back", 64'(mem_rdy), 64'd1);

        // IO write then read back of slot 2
        req(16'h0102, 16'h1234, 1'b0, 1'b1, 16'h0000, 1, 1'b1);
        check("wr_strobe", 64'(io_wr_strobe), 64'b0100);
        check("wr_slot2", 64'(io_regs[47:32]), 64'h1234);
        wait_drain(10);
        check("strobe_clear", 64'(io_wr_strobe), 64'd0);
        req(16'h0102, 16'h0, 1'b1, 1'b0, 16'h1234, 1, 1'b1);
        wait_drain(10);
        check("io_no_dram", 64'(dram_r_cnt + dram_w_cnt), 64'd0);
        check("dec_clean", 64'(err_decode), 64'd0);

        // Read-only and unimplemented slots
        req(16'h0103, 16'h0, 1'b1, 1'b0, 16'hA5A5, 1, 1'b1);
        wait_drain(10);
        req(16'h0103, 16'h1111, 1'b0, 1'b1, 16'h0000, 1, 1'b1);
        check("ro_no_strobe", 64'(io_wr_strobe), 64'd0);
        check("ro_reg_kept", 64'(io_regs[63:48]), 64'h0);
        wait_drain(10);
        check("ro_dec_err", 64'(err_decode), 64'd1);
        req(16'h0103, 16'h0, 1'b1, 1'b0, 16'hA5A5, 1, 1'b1);
        wait_drain(10);
        req(16'h0106, 16'h0, 1'b1, 1'b0, 16'h0000, 1, 1'b1);
        wait_drain(10);
        check("unimpl_dec_err", 64'(err_decode), 64'd1);
        req(16'h0105, 16'h7777, 1'b0, 1'b1, 16'h0000, 1, 1'b1);
        check("unimpl_no_strobe", 64'(io_wr_strobe), 64'd0);
        wait_drain(10);
        check("regs_after_bad_wr", io_regs, 64'h0000_1234_0000_BEEF);

        // DRAM read, 5-cycle completion
        dram_r_cnt = 0;
        drv_delay  = 5;
        drv_data   = 16'hCAFE;
        req(16'h2000, 16'h0, 1'b1, 1'b0, 16'hCAFE, 5, 1'b1);
        check("dram_rdy_low", 64'(mem_rdy), 64'd0);
        wait_drain(20);
        check("dram_r_once", 64'(dram_r_cnt), 64'd1);
        check("dram_rdy_back", 64'(mem_rdy), 64'd1);
        dram_rdy = 1'b0;
        #1 check("rdy_follows_0", 64'(mem_rdy), 64'd0);
        dram_rdy = 1'b1;
        #1 check("rdy_follows_1", 64'(mem_rdy), 64'd1);
        tick(1);

        // DRAM write, 2-cycle completion
        dram_w_cnt = 0;
        drv_delay  = 2;
        drv_data   = 16'h0000;
        req(16'h3000, 16'hABCD, 1'b0, 1'b1, 16'h0000, 2, 1'b1);
        wait_drain(20);
        check("dram_w_once", 64'(dram_w_cnt), 64'd1);
        check("no_timeout_yet", 64'(err_timeout), 64'd0);

        // Timeout after 8 wait cycles, late completion at cycle 20
        drv_delay = 20;
        drv_data  = 16'h1234;
        c = cyc;
        req(16'h4000, 16'h0, 1'b1, 1'b0, 16'hFFFF, 9, 1'b1);
        wait_drain(20);
        check("to_err", 64'(err_timeout), 64'd1);
        check("drain_rdy_low", 64'(mem_rdy), 64'd0);
        while (cyc < c + 20) tick(1);
        check("drain_rdy_late", 64'(mem_rdy), 64'd0);
        tick(1);
        check("drain_rdy_back", 64'(mem_rdy), 64'd1);

        // Reset while waiting on DRAM
        drv_delay = 30;
        c = cyc;
        req(16'h5000, 16'h0, 1'b1, 1'b0, 16'h0000, 0, 1'b0);
        tick(2);
        check("wait_rdy_low", 64'(mem_rdy), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_rdy", 64'(mem_rdy), 64'd1);
        check("arst_cplt", 64'(mem_cplt), 64'd0);
        check("arst_data", 64'(mem_data_out), 64'd0);
        check("arst_errs", 64'({err_timeout, err_decode}), 64'd0);
        check("arst_regs", io_regs, 64'h0000_0000_0000_BEEF);
        check("arst_strobe", 64'(io_wr_strobe), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        while (cyc < c + 32) tick(1);

        // Both enables high: a read, slot 0 untouched
        req(16'h0100, 16'h5555, 1'b1, 1'b1, 16'hBEEF, 1, 1'b1);
        check("both_no_strobe", 64'(io_wr_strobe), 64'd0);
        wait_drain(10);
        check("both_slot0", 64'(io_regs[15:0]), 64'hBEEF);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
